difftest_step_batcher: RTL

- Sits directly upstream of the difftest simulation endpoint and drives its step-count input and its 64-bit exit-code input.
- Accumulates per-cycle DUT commit counts into batched step pulses, which reduces the number of per-step golden-model calls.
- Orders the exit code behind all pending steps, so a trap never overtakes commits the endpoint has not yet stepped.

---
 rtl/difftest_step_batcher.sv | 122 ++++++++++++
 1 files changed

// File: rtl/difftest_step_batcher.sv
// difftest_step_batcher
//   Batches per-cycle commit counts into step pulses for the difftest
//   endpoint. This cuts down the number of golden-model step calls. The
//   block also holds back the DUT exit code until every pending step has
//   been emitted.
//
//   Ports:
//     clock     clock
//     reset     synchronous reset, active-low
//     in_step   instructions committed this cycle
//     in_flush  emit the pending count this cycle regardless of BATCH
//     in_exit   DUT exit code (0 = none, all-ones = good trap, else error)
//     out_step  registered step count to the endpoint (0 = no step)
//     out_exit  registered exit code to the endpoint
//     busy      registered; high while a count is pending or once an exit
//               has been seen
//
//   state | meaning
//   RUN   | accumulating counts, emitting on batch/flush/timeout
//   DRAIN | exit seen; emit the saturation remainder (may be 0)
//   EXIT  | present held exit code; terminal until reset
module difftest_step_batcher #(
  parameter int STEPWIDTH = 8,
  parameter int BATCH     = 16,
  parameter int TIMEOUT   = 64,
  parameter int TIMERW    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [STEPWIDTH-1:0] in_step,
  input  logic                 in_flush,
  input  logic [63:0]          in_exit,
  output logic [STEPWIDTH-1:0] out_step,
  output logic [63:0]          out_exit,
  output logic                 busy
);

  localparam logic [STEPWIDTH:0]   BATCH_W = (STEPWIDTH+1)'(BATCH);
  localparam logic [TIMERW-1:0]    T_LAST  = TIMERW'(TIMEOUT - 1);
  localparam logic [STEPWIDTH-1:0] MAX_S   = {STEPWIDTH{1'b1}};

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    EXIT  = 2'd2
  } state_t;

  state_t               state;
  logic [STEPWIDTH-1:0] acc;
  logic [TIMERW-1:0]    timer;
  logic [63:0]          exit_hold;

  logic [STEPWIDTH:0]   sum;
  logic [STEPWIDTH-1:0] sat;
  logic [STEPWIDTH-1:0] rem;
  logic                 emit;

  always_comb begin
    sum = {1'b0, acc} + {1'b0, in_step};
    // sum never exceeds 2*MAX. When it overflows, the low bits are sum-2^W,
    // so the remainder sum-MAX is low+1. That cannot wrap.
    sat = sum[STEPWIDTH] ? MAX_S : sum[STEPWIDTH-1:0];
    rem = sum[STEPWIDTH] ? (sum[STEPWIDTH-1:0] + 1'b1) : '0;
    emit = (sum >= BATCH_W)
         | ((sum != '0) & in_flush)
         | ((acc != '0) & (timer == T_LAST));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= RUN;
      acc       <= '0;
      timer     <= '0;
      exit_hold <= '0;
      out_step  <= '0;
      out_exit  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (in_exit != 64'd0) begin
            exit_hold <= in_exit;
            out_step  <= sat;
            acc       <= rem;
            timer     <= '0;
            state     <= DRAIN;
            busy      <= 1'b1;
          end else if (emit) begin
            out_step <= sat;
            acc      <= rem;
            timer    <= '0;
            busy     <= (rem != '0);
          end else begin
            out_step <= '0;
            acc      <= sum[STEPWIDTH-1:0];
            timer    <= (acc != '0) ? timer + 1'b1 : '0;
            busy     <= (sum != '0);
          end
        end
        DRAIN: begin
          out_step <= acc;
          acc      <= '0;
          state    <= EXIT;
          busy     <= 1'b1;
        end
        EXIT: begin
          out_step <= '0;
          out_exit <= exit_hold;
          busy     <= 1'b1;
        end
        default: begin
          state    <= RUN;
          out_step <= '0;
          acc      <= '0;
          timer    <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
